seg7_scan: RTL and testbench
============================

# seg7_scan

Four-digit multiplexed scan controller that sits directly upstream of the hex-to-seven-segment decoder. It holds a 16-bit value, time-multiplexes one nibble at a time onto the decoder's 4-bit input, and drives the active-low common digit enables. The digit enables are 4'b0111 when the leftmost digit is lit. A per-slot blanking window suppresses ghosting, and frame-synchronous value update prevents tearing.

## Interface
- `DIV`, default 50000: clock cycles per digit slot. Must be ≥ 2.
- `BLANK`, default 1000: cycles at the start of each slot with all digits off. Range 0 ≤ BLANK < DIV.
- `clk` input 1: system clock. One clock domain only.
- `rst_n` input 1: reset, asynchronous, active-low.
- `load` input 1: capture strobe for `value`, active for one cycle.
- `value` input 16: display value. `[15:12]` is digit 3 (leftmost) and `[3:0]` is digit 0.
- `lz_en` input 1: enables leading-zero blanking. Sampled every cycle.
- `data` output 4: nibble for the decoder. Registered.
- `digit_sel` output 4: active-low digit enables. Bit i low lights digit i. At most one bit is low at any time.
- `frame_done` output 1: one-cycle pulse marking the start of a new frame. Registered.

## Operation
- Internal state:
  - slot counter `cnt` runs 0..DIV-1 and gives the slot position p.
  - digit index `idx` gives the current digit d.
  - `pending[15:0]` plus `pend_valid` hold a captured value not yet displayed.
  - `shadow[15:0]` holds the value being displayed.
- Scan order is d = 3, 2, 1, 0, then wraps back to 3. A frame lasts 4·DIV cycles.
- Per-slot state machine:
  - S_BLANK while p < BLANK: `digit_sel` = 4'b1111.
  - S_SHOW while p ≥ BLANK: `digit_sel` has bit d low, unless the digit is suppressed.
  - When BLANK = 0, S_BLANK is never entered.
- `data` = `shadow[4d+3:4d]` for the whole slot. It is updated in the first cycle of each slot, so it is stable throughout S_BLANK before the digit turns on.
- Leading-zero suppression applies when `lz_en` = 1, d ≠ 0, and `shadow` nibbles d..3 are all zero. In that case `digit_sel` stays 4'b1111 for the whole slot. Digit 0 is never suppressed.
- Load capture:
  - When `load` = 1, `value` goes into `pending` and `pend_valid` is set.
  - Repeated loads within one frame overwrite `pending`; the last one wins.
- Frame boundary is the cycle where p = DIV-1 and d = 0. On that edge:
  - If `load` = 1 in that same cycle, `shadow` ← `value`. The new value bypasses `pending`.
  - Else if `pend_valid` = 1, `shadow` ← `pending`.
  - `pend_valid` is cleared in both cases.
  - `frame_done` pulses in the following cycle, which is the first cycle of the digit-3 slot.
- `shadow` never changes except at a frame boundary.
- Reset (asynchronous, any time including mid-slot):
  - `digit_sel` = 4'b1111, `data` = 4'h0, `frame_done` = 0.
  - `cnt` = 0, `idx` = 3, `shadow` = 0, `pending` = 0, `pend_valid` = 0.
  - A load captured before the reset is lost.

## Timing
- The first rising edge after `rst_n` deasserts is cycle 0 of the digit-3 slot.
- All outputs are registered and change only on `clk` rising edges, except when forced by reset.
- Load-to-display latency:
  - The loaded value is shown from the first cycle of the next frame.
  - Worst case is 4·DIV cycles.
  - Best case is 1 cycle, when `load` coincides with the frame boundary.
- `digit_sel` transitions to lit only after at least BLANK cycles of all-off following a `data` change.
- `frame_done` is high for exactly one cycle every 4·DIV cycles.
- The counter widths are $clog2(DIV), with no overflow: `cnt` returns 0 after DIV-1.

## Structure
- Package `seg7_pkg` contains:
  - `DIGITS` = 4.
  - `SEL_OFF` = 4'b1111.
  - The state enum `{S_BLANK, S_SHOW}`.
  - A function mapping d to its active-low one-hot select.
- One sub-module, `seg7_slot_timer`, owns `cnt` and `idx`. It outputs `slot_start`, `in_blank`, `frame_end` and `idx`.
- The top module owns `pending`, `shadow`, suppression logic and the output registers.

## Test plan
All scenarios use DIV = 8, BLANK = 2.

1. **Reset then idle.** After reset, the per-slot `digit_sel` sequence is:
   - digit 3: 1111, 1111, then 0111 ×6
   - digit 2: 1111 ×2, then 1011 ×6
   - digit 1: 1111 ×2, then 1101 ×6
   - digit 0: 1111 ×2, then 1110 ×6

   `data` = 0 throughout. `frame_done` pulses at cycles 32, 64, ….
2. **Load mid-frame.** `load` with 16'h12AB at cycle 5. `data` stays 0 until cycle 32, then reads 1, 2, A, B in successive slots.
3. **Load at boundary.** `load` with 16'hBEEF in cycle 31. Cycle 32 shows `data` = B with `frame_done` = 1.
4. **Double load.** Loads of 16'h1111 at cycle 3 and 16'h2222 at cycle 10. The next frame shows 2, 2, 2, 2; 16'h1111 never appears.
5. **Leading zeros.** `lz_en` = 1 with value 16'h0005. The digit 3, 2 and 1 slots are 1111 for all 8 cycles. The digit-0 slot is 1111, 1111, then 1110 ×6 with `data` = 5. Value 16'h0000 shows only digit 0 with `data` = 0.
6. **Reset mid-slot.** Assert `rst_n` = 0 during digit-1 S_SHOW with `pend_valid` set. Outputs go to reset values immediately. After release, the scan restarts at digit 3 with `shadow` = 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, slot state type and digit-select helper for the seg7 scan controller
package seg7_pkg;

    localparam int DIGITS = 4;
    localparam logic [3:0] SEL_OFF = 4'b1111;

    typedef enum logic {S_BLANK, S_SHOW} state_t;

    function automatic logic [3:0] sel_of(input logic [1:0] d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: slot counter and digit index; flags describe the cycle the output registers present next
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       slot_start,
    output logic       in_blank,
    output logic       frame_end,
    output logic [1:0] idx
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [1:0]    dig;

    // next slot position, next digit and boundary flags from the current position
    always_comb begin
        slot_start = cnt == CW'(DIV - 1);
        frame_end  = slot_start && dig == 2'd0;
        cnt_nx     = slot_start ? '0 : cnt + 1'b1;
        idx        = slot_start ? (dig == 2'd0 ? 2'(DIGITS - 1) : dig - 2'd1) : dig;
        in_blank   = int'(cnt_nx) < BLANK;
    end

    // advance the slot counter; wrap digit 0 back to the leftmost digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dig <= 2'(DIGITS - 1);
        end else begin
            cnt <= cnt_nx;
            dig <= idx;
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed display scanner with blanking, leading-zero suppression and frame-synchronous update
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        lz_en,
    output logic [3:0]  data,
    output logic [3:0]  digit_sel,
    output logic        frame_done
);

    logic        slot_start;
    logic        in_blank;
    logic        frame_end;
    logic [1:0]  idx;
    logic [15:0] pending;
    logic        pend_valid;
    logic [15:0] shadow;
    logic [15:0] shadow_nx;
    logic        suppress;
    state_t      state;

    seg7_slot_timer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot_start (slot_start),
        .in_blank   (in_blank),
        .frame_end  (frame_end),
        .idx        (idx)
    );

    // displayed value only moves at the frame boundary; a load in that very cycle bypasses pending
    always_comb begin
        shadow_nx = frame_end ? (load ? value : pend_valid ? pending : shadow) : shadow;
        suppress  = lz_en && idx != 2'd0 && (shadow_nx >> {idx, 2'b00}) == 16'h0;
        state     = in_blank ? S_BLANK : S_SHOW;
    end

    // capture loads into pending (last wins) and commit to shadow at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 16'h0;
            pend_valid <= 1'b0;
            shadow     <= 16'h0;
        end else begin
            if (load)
                pending <= value;
            pend_valid <= frame_end ? 1'b0 : (load ? 1'b1 : pend_valid);
            shadow     <= shadow_nx;
        end
    end

    // output registers reflect the slot position of the cycle that follows the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= 4'h0;
            digit_sel  <= SEL_OFF;
            frame_done <= 1'b0;
        end else begin
            data       <= slot_start ? shadow_nx[{idx, 2'b00} +: 4] : data;
            digit_sel  <= (state == S_SHOW && !suppress) ? sel_of(idx) : SEL_OFF;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed scenarios checked against a frame-level display model plus literal spot checks
module tb_seg7_scan;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        lz_en;
    logic [3:0]  data;
    logic [3:0]  digit_sel;
    logic        frame_done;

    seg7_scan #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .lz_en      (lz_en),
        .data       (data),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    typedef struct {
        int          c;
        logic [15:0] v;
    } ld_t;

    ld_t  lq[$];
    int   t;
    logic lzq;
    logic chk_on;
    int   n_cmp;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // the value on display in frame f is the last value loaded in any cycle before that frame began
    function automatic logic [15:0] shown(input int f);
        logic [15:0] v;
        v = 16'h0;
        foreach (lq[i])
            if (lq[i].c < FRAME * f)
                v = lq[i].v;
        return v;
    endfunction

    task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", n, t, got, exp);
        end
    endtask

    // model bookkeeping: cycle number since reset release, load history, sampled lz_en
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t   <= 0;
            lzq <= 1'b0;
            lq.delete();
        end else begin
            if (load)
                lq.push_back('{t, value});
            t   <= t + 1;
            lzq <= lz_en;
        end
    end

    // every-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_on) begin
            logic [15:0] v;
            logic [3:0]  oh;
            logic [3:0]  esel;
            logic [3:0]  edata;
            logic        efd;
            int          p;
            int          d;
            logic        sup;
            if (!rst_n) begin
                esel  = 4'hF;
                edata = 4'h0;
                efd   = 1'b0;
            end else begin
                p     = t % DIV;
                d     = 3 - (t / DIV) % 4;
                v     = shown(t / FRAME);
                sup   = lzq && d != 0 && (v >> (4 * d)) == 16'h0;
                oh    = 4'b0001 << d;
                esel  = (p < BLANK || sup) ? 4'hF : ~oh;
                edata = v[4*d +: 4];
                efd   = (t % FRAME == 0) && t > 0;
            end
            chk("cyc digit_sel", {12'h0, digit_sel}, {12'h0, esel});
            chk("cyc data", {12'h0, data}, {12'h0, edata});
            chk("cyc frame_done", {15'h0, frame_done}, {15'h0, efd});
        end
    end

    task automatic to_cyc(input int n);
        int g;
        g = 0;
        while (t < n && g < 2000) begin
            @(posedge clk);
            #2;
            g++;
        end
        if (t < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout waiting for cycle %0d at t=%0d", n, t);
        end
    endtask

    task automatic look(input int n);
        to_cyc(n);
        @(negedge clk);
    endtask

    task automatic ld(input int n, input logic [15:0] v);
        to_cyc(n);
        load  = 1'b1;
        value = v;
        to_cyc(n + 1);
        load  = 1'b0;
    endtask

    task automatic do_rst;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        load  = 1'b0;
        lz_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b1;
        load   = 1'b0;
        value  = 16'h0;
        lz_en  = 1'b0;
        chk_on = 1'b0;
        #1 rst_n = 1'b0;
        #2 chk_on = 1'b1;

        // reset then idle
        do_rst();
        #1;
        chk("idle sel c0", {12'h0, digit_sel}, 16'hF);
        look(1);  chk("idle sel c1", {12'h0, digit_sel}, 16'hF);
        look(2);  chk("idle sel c2", {12'h0, digit_sel}, 16'h7);
        look(9);  chk("idle sel c9", {12'h0, digit_sel}, 16'hF);
        look(10); chk("idle sel c10", {12'h0, digit_sel}, 16'hB);
        look(18); chk("idle sel c18", {12'h0, digit_sel}, 16'hD);
        look(31); chk("idle sel c31", {12'h0, digit_sel}, 16'hE);
        chk("idle fd c31", {15'h0, frame_done}, 16'h0);
        look(32); chk("idle fd c32", {15'h0, frame_done}, 16'h1);
        look(64); chk("idle fd c64", {15'h0, frame_done}, 16'h1);

        // load mid-frame
        do_rst();
        ld(5, 16'h12AB);
        look(31); chk("mid data c31", {12'h0, data}, 16'h0);
        look(32); chk("mid data c32", {12'h0, data}, 16'h1);
        look(40); chk("mid data c40", {12'h0, data}, 16'h2);
        look(48); chk("mid data c48", {12'h0, data}, 16'hA);
        look(56); chk("mid data c56", {12'h0, data}, 16'hB);

        // load at frame boundary
        do_rst();
        look(30); chk("bnd data c30", {12'h0, data}, 16'h0);
        ld(31, 16'hBEEF);
        look(32);
        chk("bnd data c32", {12'h0, data}, 16'hB);
        chk("bnd fd c32", {15'h0, frame_done}, 16'h1);
        look(40); chk("bnd data c40", {12'h0, data}, 16'hE);

        // double load, last wins
        do_rst();
        ld(3, 16'h1111);
        ld(10, 16'h2222);
        look(32); chk("dbl data c32", {12'h0, data}, 16'h2);
        look(40); chk("dbl data c40", {12'h0, data}, 16'h2);
        look(48); chk("dbl data c48", {12'h0, data}, 16'h2);
        look(56); chk("dbl data c56", {12'h0, data}, 16'h2);

        // leading-zero suppression
        do_rst();
        lz_en = 1'b1;
        ld(1, 16'h0005);
        look(34); chk("lz sel c34", {12'h0, digit_sel}, 16'hF);
        look(42); chk("lz sel c42", {12'h0, digit_sel}, 16'hF);
        look(50); chk("lz sel c50", {12'h0, digit_sel}, 16'hF);
        look(57); chk("lz sel c57", {12'h0, digit_sel}, 16'hF);
        look(58); chk("lz sel c58", {12'h0, digit_sel}, 16'hE);
        chk("lz data c58", {12'h0, data}, 16'h5);
        ld(70, 16'h0000);
        look(98);  chk("lz0 sel c98", {12'h0, digit_sel}, 16'hF);
        look(122); chk("lz0 sel c122", {12'h0, digit_sel}, 16'hE);
        chk("lz0 data c122", {12'h0, data}, 16'h0);

        // reset mid-slot with a pending load
        do_rst();
        ld(3, 16'hABCD);
        ld(40, 16'h1234);
        look(50); chk("mrst sel c50", {12'h0, digit_sel}, 16'hD);
        chk("mrst data c50", {12'h0, data}, 16'hC);
        to_cyc(51);
        rst_n = 1'b0;
        #1;
        chk("mrst sel async", {12'h0, digit_sel}, 16'hF);
        chk("mrst data async", {12'h0, data}, 16'h0);
        chk("mrst fd async", {15'h0, frame_done}, 16'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        look(2);  chk("mrst sel c2", {12'h0, digit_sel}, 16'h7);
        look(32); chk("mrst data c32", {12'h0, data}, 16'h0);
        look(40); chk("mrst data c40", {12'h0, data}, 16'h0);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
